// File: rtl/seg7_scan_mux_pkg.sv
// Shared widths and constants for the 7-segment digit scanner.
package seg7_scan_mux_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam logic        ANODE_OFF = 1'b1;

endpackage

// File: rtl/seg7_scan_mux_prescaler.sv
// Slot-rate prescaler: counts 0..REFRESH_DIV-1 while enabled and flags the last count.
module scan_prescaler #(
  parameter  int unsigned REFRESH_DIV = 50000,
  localparam int unsigned PS_W        = $clog2(REFRESH_DIV)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  output logic [PS_W-1:0] o_ps,
  output logic            o_tc_c
);

  logic [PS_W-1:0] r_ps;
  logic            w_last;

  assign w_last = (r_ps == PS_W'(REFRESH_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ps <= '0;
    end else if (i_en) begin
      r_ps <= w_last ? '0 : r_ps + PS_W'(1);
    end
  end

  assign o_ps   = r_ps;
  assign o_tc_c = i_en & w_last;

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a common-anode 7-segment display with dead time,
// leading-zero blanking and a per-frame snapshot of the input digits.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [BCD_W*N_DIGITS-1:0] i_digits,
  input  logic [N_DIGITS-1:0]       i_dp_in,
  input  logic                      i_lz_blank,
  output logic [BCD_W-1:0]          o_num,
  output logic                      o_dp,
  output logic [N_DIGITS-1:0]       o_an,
  output logic                      o_blank,
  output logic                      o_frame
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned PS_W  = $clog2(REFRESH_DIV);

  logic [PS_W-1:0]                  w_ps;
  logic                             w_tc;
  logic                             w_wrap;
  logic                             w_live;
  logic                             w_blanked;
  logic                             w_visible;
  logic [N_DIGITS-1:0]              w_zero_from;
  logic [N_DIGITS-1:0]              w_onehot;

  logic [IDX_W-1:0]                 r_idx;
  logic [N_DIGITS-1:0][BCD_W-1:0]   r_snap_d;
  logic [N_DIGITS-1:0]              r_snap_dp;
  logic [BCD_W-1:0]                 r_num;
  logic                             r_dp;
  logic [N_DIGITS-1:0]              r_an;
  logic                             r_blank;
  logic                             r_frame;

  scan_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_ps (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .o_ps   (w_ps),
    .o_tc_c (w_tc)
  );

  // Dead time opens each slot with all anodes off to suppress ghosting.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign w_live = 1'b1;
  end else begin : g_dead
    assign w_live = (w_ps >= PS_W'(DEAD_CYCLES));
  end

  // w_zero_from[i]: snapshot nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    w_zero_from = '0;
    w_zero_from[N_DIGITS-1] = (r_snap_d[N_DIGITS-1] == '0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      w_zero_from[i] = (r_snap_d[i] == '0) & w_zero_from[i+1];
    end
  end

  assign w_blanked = i_lz_blank & (r_idx != '0) & w_zero_from[r_idx];
  assign w_visible = i_en & w_live & ~w_blanked;
  assign w_wrap    = w_tc & (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_onehot  = N_DIGITS'(1) << r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx     <= '0;
      r_snap_d  <= '0;
      r_snap_dp <= '0;
      r_num     <= '0;
      r_dp      <= 1'b0;
      r_an      <= {N_DIGITS{ANODE_OFF}};
      r_blank   <= 1'b1;
      r_frame   <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      r_num   <= r_snap_d[r_idx];
      if (w_visible) begin
        r_an    <= ~w_onehot;
        r_dp    <= r_snap_dp[r_idx];
        r_blank <= 1'b0;
      end else begin
        r_an    <= {N_DIGITS{ANODE_OFF}};
        r_dp    <= 1'b0;
        r_blank <= 1'b1;
      end
      if (w_tc) begin
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      // Inputs are only sampled at the frame wrap so a frame is always coherent.
      if (w_wrap) begin
        r_snap_d  <= i_digits;
        r_snap_dp <= i_dp_in;
      end
    end
  end

  assign o_num   = r_num;
  assign o_dp    = r_dp;
  assign o_an    = r_an;
  assign o_blank = r_blank;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux (4 digits, 4-cycle slots, 1 dead cycle).
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  o_num;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_blank;
  logic        o_frame;
  logic [10:0] w_obs;

  int total = 0;
  int bad   = 0;

  seg7_scan_mux #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_digits   (digits),
    .i_dp_in    (dp_in),
    .i_lz_blank (lz_blank),
    .o_num      (o_num),
    .o_dp       (o_dp),
    .o_an       (o_an),
    .o_blank    (o_blank),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {AN, NUM, DP, BLANK, FRAME}.
  assign w_obs = {o_an, o_num, o_dp, o_blank, o_frame};

  function automatic logic [10:0] pk(input logic [3:0] an, input logic [3:0] num,
                                     input logic dp, input logic bl, input logic fr);
    return {an, num, dp, bl, fr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    rst = 1'b1;
    digits = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = pk(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0);
      total++;
      if (w_obs !== exp_v) begin
        bad++;
        $display("FAIL reset cyc%0d: got %h want %h", i, w_obs, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_order();
    logic [3:0]  an_on [4];
    logic [3:0]  nums  [4];
    logic [10:0] exp_v;
    logic        vis;
    an_on = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    nums  = '{4'd4, 4'd3, 4'd2, 4'd1};
    digits = 16'h1234; lz_blank = 1'b0; dp_in = 4'b0100; en = 1'b1;
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          vis = (c != 0);
          exp_v = pk(vis ? an_on[s] : 4'b1111, (f == 1) ? nums[s] : 4'd0,
                     vis && f == 1 && s == 2, !vis, s == 3 && c == 3);
          total++;
          if (w_obs !== exp_v) begin
            bad++;
            $display("FAIL scan f%0d s%0d c%0d: got %h want %h", f, s, c, w_obs, exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [3:0]  an_on [4];
    logic [10:0] exp_v;
    logic        vis;
    an_on = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    digits = 16'h0070; lz_blank = 1'b1; dp_in = 4'b0000; en = 1'b1;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (f == 1 && s == 0 && c == 0) digits = 16'h0000;
          tick();
          vis = (c != 0) && (s == 0 || (f == 1 && s == 1));
          exp_v = pk(vis ? an_on[s] : 4'b1111, (f == 1 && s == 1) ? 4'd7 : 4'd0,
                     1'b0, !vis, s == 3 && c == 3);
          total++;
          if (w_obs !== exp_v) begin
            bad++;
            $display("FAIL lzb f%0d s%0d c%0d: got %h want %h", f, s, c, w_obs, exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [3:0]  an_on [4];
    logic [3:0]  nums  [3][4];
    logic [10:0] exp_v;
    logic        vis;
    an_on = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    nums  = '{'{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd8, 4'd7, 4'd6, 4'd5}};
    digits = 16'h1234; lz_blank = 1'b0; dp_in = 4'b0000; en = 1'b1;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          vis = (c != 0);
          exp_v = pk(vis ? an_on[s] : 4'b1111, nums[f][s], 1'b0, !vis, s == 3 && c == 3);
          total++;
          if (w_obs !== exp_v) begin
            bad++;
            $display("FAIL snap f%0d s%0d c%0d: got %h want %h", f, s, c, w_obs, exp_v);
          end
          if (f == 1 && s == 1 && c == 1) digits = 16'h5678;
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [10:0] exp_tab [14];
    exp_tab = '{
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),   // edge 25: slot 2 dead
      pk(4'b1011, 4'd2, 1'b0, 1'b0, 1'b0),   // edge 26: slot 2 PS=1
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),   // edges 27..31: EN low
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),
      pk(4'b1111, 4'd2, 1'b0, 1'b1, 1'b0),
      pk(4'b1011, 4'd2, 1'b0, 1'b0, 1'b0),   // edge 32: resume at PS=2
      pk(4'b1011, 4'd2, 1'b0, 1'b0, 1'b0),
      pk(4'b1111, 4'd1, 1'b0, 1'b1, 1'b0),   // edge 34: slot 3 dead
      pk(4'b0111, 4'd1, 1'b0, 1'b0, 1'b0),
      pk(4'b0111, 4'd1, 1'b0, 1'b0, 1'b0),
      pk(4'b0111, 4'd1, 1'b0, 1'b0, 1'b1),   // edge 37: wrap
      pk(4'b1111, 4'd4, 1'b0, 1'b1, 1'b0)    // edge 38: slot 0 dead
    };
    digits = 16'h1234; lz_blank = 1'b0; dp_in = 4'b0000; en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 24; k++) tick();
    for (int k = 25; k <= 38; k++) begin
      tick();
      total++;
      if (w_obs !== exp_tab[k-25]) begin
        bad++;
        $display("FAIL enable edge%0d: got %h want %h", k, w_obs, exp_tab[k-25]);
      end
      if (k == 26) en = 1'b0;
      if (k == 31) en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  an_on [4];
    logic [10:0] exp_v;
    logic        vis;
    an_on = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    digits = 16'h1234; lz_blank = 1'b0; dp_in = 4'b0000; en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 25; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = pk(4'b1111, 4'd0, 1'b0, 1'b1, 1'b0);
    total++;
    if (w_obs !== exp_v) begin
      bad++;
      $display("FAIL rstmid reset: got %h want %h", w_obs, exp_v);
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        vis = (c != 0);
        exp_v = pk(vis ? an_on[s] : 4'b1111, 4'd0, 1'b0, !vis, s == 3 && c == 3);
        total++;
        if (w_obs !== exp_v) begin
          bad++;
          $display("FAIL rstmid s%0d c%0d: got %h want %h", s, c, w_obs, exp_v);
        end
      end
    end
    tick();
    exp_v = pk(4'b1111, 4'd4, 1'b0, 1'b1, 1'b0);
    total++;
    if (w_obs !== exp_v) begin
      bad++;
      $display("FAIL rstmid reload dead: got %h want %h", w_obs, exp_v);
    end
    tick();
    exp_v = pk(4'b1110, 4'd4, 1'b0, 1'b0, 1'b0);
    total++;
    if (w_obs !== exp_v) begin
      bad++;
      $display("FAIL rstmid reload show: got %h want %h", w_obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; digits = 16'h0000; dp_in = 4'b0000; lz_blank = 1'b0;
    test_reset();
    test_scan_order();
    test_leading_zeros();
    test_snapshot();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed display scanner for an N-digit common-anode 7-segment display. It sits directly upstream of the BCD-to-7-segment decoder:
- drives the decoder's 4-bit NUM input one digit at a time;
- drives the active-low digit anodes AN in lockstep.

It adds per-slot dead time against ghosting, leading-zero blanking, per-digit decimal point, and a frame-coherent snapshot of the input digits.

Parameters:
- N_DIGITS, 4: number of digits scanned; must be >= 2.
- REFRESH_DIV, 50000: CLK cycles per digit slot; must be > DEAD_CYCLES and >= 2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off; 0 allowed.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  scan enable.
- DIGITS  in  4*N_DIGITS  BCD digits; nibble i = DIGITS[4i+3:4i]; digit 0 is least significant.
- DP_IN  in  N_DIGITS  decimal point request per digit.
- LZ_BLANK  in  1  leading-zero blanking enable.
- NUM  out  4  BCD value of the current digit, fed to the decoder.
- DP  out  1  decimal point of the current digit, active-high.
- AN  out  N_DIGITS  digit anodes, active-low; AN[i] selects digit i.
- BLANK  out  1  forces decoder segments off; high whenever AN is all ones.
- FRAME  out  1  one-cycle pulse at scan wrap.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high: sampled only on the CLK rising edge.
- Reset values (visible the cycle after RST is sampled high):
  - AN = all ones, NUM = 0, DP = 0, BLANK = 1, FRAME = 0;
  - prescaler PS = 0, digit index IDX = 0, snapshot SNAP_D = 0, SNAP_DP = 0.
- Reset mid-operation: discard the slot in progress and restart from IDX 0 with an empty snapshot.
- Prescaler, when EN = 1:
  - PS counts 0 .. REFRESH_DIV-1.
  - At PS = REFRESH_DIV-1: PS goes to 0 and IDX increments.
  - IDX wraps N_DIGITS-1 -> 0.
- Wrap event (PS terminal and IDX = N_DIGITS-1):
  - SNAP_D <= DIGITS and SNAP_DP <= DP_IN;
  - FRAME = 1 for exactly one cycle, in the cycle after the wrap edge.
- DIGITS and DP_IN are used only through the snapshot. A mid-frame change takes effect only at the next wrap.
- Blanking rule for digit i: blanked when LZ_BLANK = 1, i != 0, and SNAP_D nibbles i .. N_DIGITS-1 are all zero. Digit 0 is never blanked.
- All outputs are registered; each cycle's outputs reflect the PS, IDX and snapshot values of the previous cycle.
- Digit visible when EN = 1, PS >= DEAD_CYCLES, and digit IDX not blanked:
  - AN[IDX] = 0, all other AN bits = 1;
  - NUM = SNAP_D nibble IDX;
  - DP = SNAP_DP[IDX];
  - BLANK = 0.
- Otherwise (dead time, blanked digit, or EN = 0): AN = all ones, BLANK = 1, DP = 0, NUM = SNAP_D nibble IDX.
- EN = 0: PS, IDX and snapshot hold; FRAME = 0. Re-enabling resumes the same slot at the held PS.
- Non-BCD nibbles (10-15) are passed to NUM unchanged; decoding them is the decoder's responsibility. A nonzero non-BCD nibble counts as non-zero for blanking.
- IDX width = clog2(N_DIGITS); PS width = clog2(REFRESH_DIV). No state outside 0 .. limit-1 is reachable.

Decomposition:
- Shared package/header: BCD digit width (4) and the anode-off constant.
- One natural sub-module, scan_prescaler:
  - parameter REFRESH_DIV;
  - inputs CLK, RST, EN;
  - outputs PS count and terminal-count pulse TC.
- seg7_scan_mux owns IDX, the snapshot, the blanking logic and the output registers.

Test Plan:
Bench parameters for all scenarios: N_DIGITS = 4, REFRESH_DIV = 4, DEAD_CYCLES = 1, EN = 1 unless stated.
1. Reset: RST high for 3 cycles with DIGITS = 16'h1234 -> AN = 4'b1111, NUM = 0, DP = 0, BLANK = 1, FRAME = 0 throughout.
2. Scan order: DIGITS = 16'h1234, LZ_BLANK = 0, DP_IN = 4'b0100.
   - First frame shows digit 0 as NUM = 0; FRAME pulses once after 16 cycles.
   - Second frame, each slot is 1 dead cycle (AN = 1111) then 3 cycles of: AN = 1110/NUM = 4, AN = 1101/NUM = 3, AN = 1011/NUM = 2 with DP = 1, AN = 0111/NUM = 1.
3. Leading zeros: DIGITS = 16'h0070, LZ_BLANK = 1.
   - Slots 2 and 3 keep AN = 1111, BLANK = 1.
   - Slot 1 shows NUM = 7; slot 0 shows NUM = 0.
   - With DIGITS = 16'h0000, only AN = 1110 is ever asserted.
4. Snapshot coherency: switch DIGITS from 16'h1234 to 16'h5678 during slot 1 -> slots 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
5. Enable gating: drop EN for 5 cycles at PS = 2 of slot 2 -> AN = 1111, BLANK = 1 while low; IDX and PS frozen; after re-enable, slot 2 completes its remaining cycles, then slot 3.
6. Reset mid-scan: assert RST for 1 cycle during slot 2 -> next cycle has reset values; scanning restarts at slot 0 with NUM = 0 until the next wrap loads a new snapshot.
